// File: rtl/wm8731_pkg.sv
// Shared types and constants for the WM8731 I2C register initialiser:
// device address, state encoding, boot register table and slot pin decode.
package wm8731_pkg;

   localparam logic [7:0] WM8731_ADDR_W = 8'h34;

   // Bus-idle slots after each STOP; pads every register write to a 34-slot frame.
   localparam int GAP_SLOTS = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_BIT,
      ST_STOP,
      ST_GAP,
      ST_DONE
   } i2c_state_e;

   typedef struct packed {
      logic scl;
      logic sda_low;
   } pins_t;

   localparam logic [15:0] WM8731_INIT_TBL [7] = '{
      16'h1E00,  // reset
      16'h0815,  // analog path
      16'h0A00,  // digital path
      16'h0C00,  // power
      16'h0E42,  // master, I2S, 16 bit
      16'h1019,  // sampling
      16'h1201   // active
   };

   // Pin levels for one quarter of a slot. sda_low=1 pulls SDA down, 0 releases it.
   function automatic pins_t slot_pins(i2c_state_e st, logic [1:0] q,
                                       logic data_bit, logic ack_slot);
      pins_t p;
      p.scl     = 1'b1;
      p.sda_low = 1'b0;
      case (st)
         ST_START: p.sda_low = q[1];
         ST_BIT: begin
            p.scl     = q[1];
            p.sda_low = !ack_slot && !data_bit;
         end
         ST_STOP: begin
            p.scl     = (q != 2'd0);
            p.sda_low = !q[1];
         end
         default: ;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/wm8731_i2c_init_if.sv
// Control/status and SCL bundle between the codec initialiser and the system
// FSM; the open-drain SDA pad stays a plain inout on the module.
interface wm8731_i2c_init_if;
   logic start;
   logic i2c_sclk;
   logic busy;
   logic done;
   logic ack_error;

   modport master (input start, output i2c_sclk, busy, done, ack_error);
   modport slave  (output start, input i2c_sclk, busy, done, ack_error);
endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-period prescaler: one-cycle tick every CLK_DIV clocks, restartable
// so the first quarter after a start accept has full length.
module i2c_tick_gen #(
   parameter int CLK_DIV = 30
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/wm8731_i2c_init.sv
// WM8731 boot configuration over write-only I2C: sends NUM_REGS table words to
// device 0x34. Define ACK_CHECK_EN to sample ACK slots and abort on NACK.
module wm8731_i2c_init
   import wm8731_pkg::*;
#(
   parameter int CLK_DIV  = 30,
   parameter int NUM_REGS = 7
) (
   input  logic               clk,
   input  logic               rst_n,
   wm8731_i2c_init_if.master  bus,
   inout  wire                i2c_sdat
);

   localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   i2c_state_e    state, state_nx;
   logic [1:0]    q, q_nx;
   logic [3:0]    bit_cnt, bit_cnt_nx;   // data/ACK slot in BIT, gap slot in GAP
   logic [1:0]    byte_cnt, byte_cnt_nx;
   logic [RW-1:0] reg_idx, reg_idx_nx;
   logic          busy, busy_nx;
   logic          done, done_nx;
   pins_t         pins, pins_nx;
   logic          tick;
   logic          accept;
   logic [15:0]   tx_word;
   logic [7:0]    tx_byte;

   assign accept = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start;

   i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (accept),
      .tick  (tick)
   );

`ifdef ACK_CHECK_EN
   logic ack_error, ack_error_nx;
   logic ack_sample;

   // SDA is sampled on the q2->q3 tick of each ACK slot; high means NACK.
   assign ack_sample = tick && (state == ST_BIT) && (bit_cnt == 4'd8) && (q == 2'd2);

   always_comb begin
      ack_error_nx = ack_error;
      if (accept) begin
         ack_error_nx = 1'b0;
      end else if (ack_sample && i2c_sdat) begin
         ack_error_nx = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_error <= 1'b0;
      end else begin
         ack_error <= ack_error_nx;
      end
   end
`else
   logic ack_error;
   assign ack_error = 1'b0;
`endif

   // NOTE: every signal gets its hold value first, so paths that do not assign
   // it cannot infer a latch.
   always_comb begin
      state_nx    = state;
      q_nx        = q;
      bit_cnt_nx  = bit_cnt;
      byte_cnt_nx = byte_cnt;
      reg_idx_nx  = reg_idx;
      busy_nx     = busy;
      done_nx     = done;
      if (accept) begin
         state_nx    = ST_START;
         q_nx        = 2'd0;
         bit_cnt_nx  = 4'd0;
         byte_cnt_nx = 2'd0;
         reg_idx_nx  = '0;
         busy_nx     = 1'b1;
         done_nx     = 1'b0;
      end else if (tick) begin
         q_nx = q + 2'd1;
         case (state)
            ST_START: begin
               if (q == 2'd3) begin
                  state_nx    = ST_BIT;
                  bit_cnt_nx  = 4'd0;
                  byte_cnt_nx = 2'd0;
               end
            end
            ST_BIT: begin
               if (q == 2'd3) begin
                  if (bit_cnt != 4'd8) begin
                     bit_cnt_nx = bit_cnt + 4'd1;
                  end else if (ack_error || byte_cnt == 2'd2) begin
                     // A NACK skips the rest of the word and closes the bus.
                     state_nx   = ST_STOP;
                     bit_cnt_nx = 4'd0;
                  end else begin
                     bit_cnt_nx  = 4'd0;
                     byte_cnt_nx = byte_cnt + 2'd1;
                  end
               end
            end
            ST_STOP: begin
               if (q == 2'd3) begin
                  state_nx   = ST_GAP;
                  bit_cnt_nx = 4'd0;
               end
            end
            ST_GAP: begin
               if (q == 2'd3) begin
                  if (bit_cnt != 4'(GAP_SLOTS - 1)) begin
                     bit_cnt_nx = bit_cnt + 4'd1;
                  end else if (ack_error || reg_idx == RW'(NUM_REGS - 1)) begin
                     state_nx = ST_DONE;
                     busy_nx  = 1'b0;
                     done_nx  = 1'b1;
                  end else begin
                     state_nx   = ST_START;
                     bit_cnt_nx = 4'd0;
                     reg_idx_nx = reg_idx + 1'b1;
                  end
               end
            end
            default: q_nx = q;
         endcase
      end
   end

   // Pins are decoded from the next slot position and registered with it.
   always_comb begin
      tx_word = WM8731_INIT_TBL[reg_idx_nx];
      case (byte_cnt_nx)
         2'd0:    tx_byte = WM8731_ADDR_W;
         2'd1:    tx_byte = tx_word[15:8];
         default: tx_byte = tx_word[7:0];
      endcase
      pins_nx = slot_pins(state_nx, q_nx, tx_byte[3'd7 - bit_cnt_nx[2:0]],
                          bit_cnt_nx == 4'd8);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         q        <= 2'd0;
         bit_cnt  <= 4'd0;
         byte_cnt <= 2'd0;
         reg_idx  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pins     <= '{scl: 1'b1, sda_low: 1'b0};
      end else begin
         state    <= state_nx;
         q        <= q_nx;
         bit_cnt  <= bit_cnt_nx;
         byte_cnt <= byte_cnt_nx;
         reg_idx  <= reg_idx_nx;
         busy     <= busy_nx;
         done     <= done_nx;
         pins     <= pins_nx;
      end
   end

   assign bus.i2c_sclk  = pins.scl;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.ack_error = ack_error;
   assign i2c_sdat      = pins.sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_wm8731_i2c_init.sv
// Bench for wm8731_i2c_init: I2C slave model with pull-up decodes writes into
// a scoreboard; protocol, timing, restart-ignore, reset and NACK scenarios.
module tb_wm8731_i2c_init;

   localparam int CLK_DIV  = 4;
   localparam int NUM_REGS = 7;
   localparam int SEQ_CYC  = 3808;             // 7 * 136 * 4
   localparam int NACK_CYC = 3 * 544 + 25 * 16; // regs 0-2, then START+18 slots+STOP+5 gap
   localparam logic [15:0] EXP_TBL [7] = '{16'h1E00, 16'h0815, 16'h0A00, 16'h0C00,
                                          16'h0E42, 16'h1019, 16'h1201};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wm8731_i2c_init_if bus();
   wire  sdat;
   logic slave_low = 1'b0;
   pullup (sdat);
   assign sdat = slave_low ? 1'b0 : 1'bz;

   wm8731_i2c_init #(.CLK_DIV(CLK_DIV), .NUM_REGS(NUM_REGS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .i2c_sdat (sdat)
   );

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_bad = 0;
   logic [23:0] exp_q[$];

   int start_cnt = 0, stop_cnt = 0, xfer_cnt = 0, partial_cnt = 0;
   int per_cnt = 0, per_bad = 0;
   int start_base = 0;
   logic nack_en = 1'b0;
   int nack_reg = 3;
   int unsigned acc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Slave model and protocol monitor, sampled mid-cycle.
   logic scl_p = 1'b1, sda_p = 1'b1, in_xfer = 1'b0, fall_ok = 1'b0;
   int bitpos = 0, nbytes = 0, xfer_idx = 0;
   logic [7:0] shreg = '0;
   logic [23:0] rx = '0;
   int unsigned last_fall = 0;

   always @(negedge clk) begin : slave
      logic scl, sda;
      scl = bus.i2c_sclk;
      sda = (sdat !== 1'b0);
      if (scl && scl_p && sda != sda_p) begin
         if (!sda) begin
            start_cnt++;
            in_xfer  = 1'b1;
            bitpos   = 0;
            nbytes   = 0;
            fall_ok  = 1'b0;
            xfer_idx = start_cnt - start_base - 1;
         end else begin
            stop_cnt++;
            if (in_xfer) begin
               if (nbytes == 3) begin
                  xfer_cnt++;
                  if (exp_q.size() == 0) begin
                     n_vec++;
                     n_bad++;
                     $display("FAIL xfer: got %06h, none expected", rx);
                  end else begin
                     check("xfer", {8'h00, rx}, {8'h00, exp_q.pop_front()});
                  end
               end else begin
                  partial_cnt++;
               end
            end
            in_xfer = 1'b0;
         end
      end else if (in_xfer && scl && !scl_p) begin
         if (bitpos < 8) shreg = {shreg[6:0], sda};
         bitpos++;
         if (bitpos == 9) begin
            rx = {rx[15:0], shreg};
            nbytes++;
            bitpos = 0;
         end
      end else if (in_xfer && !scl && scl_p) begin
         if (fall_ok) begin
            per_cnt++;
            if (cyc - last_fall != 16) per_bad++;
         end
         last_fall = cyc;
         fall_ok   = 1'b1;
         slave_low = (bitpos == 8) && !(nack_en && xfer_idx == nack_reg && nbytes == 1);
      end
      scl_p = scl;
      sda_p = sda;
   end

   task automatic push_regs(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({8'h34, EXP_TBL[i]});
   endtask

   task automatic do_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 acc = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_after_accept", bus.busy, 1);
   endtask

   task automatic wait_done(input string name, output int unsigned lat);
      lat = 0;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (bus.done) begin
            lat = cyc - acc;
            return;
         end
      end
      n_vec++;
      n_bad++;
      $display("FAIL %s: done not seen within 6000 cycles", name);
   endtask

   initial begin
      int unsigned lat;
      int s0, p0, x0, pc0, pb0, pa0;
      bus.start = 1'b0;

      #12;
      check("rst_scl", bus.i2c_sclk, 1);
      check("rst_sda", sdat, 1);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_ack_error", bus.ack_error, 0);
      @(negedge clk) rst_n = 1'b1;

      // Full sequence, with a start pulse mid-run that must be ignored.
      s0 = start_cnt; p0 = stop_cnt; x0 = xfer_cnt; pc0 = per_cnt; pb0 = per_bad;
      start_base = start_cnt;
      push_regs(7);
      do_start();
      while (cyc < acc + 1000) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_mid_run", bus.busy, 1);
      wait_done("seq1", lat);
      check("seq1_latency", lat, SEQ_CYC);
      check("seq1_busy_end", bus.busy, 0);
      check("seq1_starts", start_cnt - s0, 7);
      check("seq1_stops", stop_cnt - p0, 7);
      check("seq1_xfers", xfer_cnt - x0, 7);
      check("seq1_scl_periods", per_cnt - pc0, 7 * 27);
      check("seq1_scl_period_err", per_bad - pb0, 0);
      check("seq1_queue_left", exp_q.size(), 0);

      // Asynchronous reset mid-transfer, then a clean rerun.
      start_base = start_cnt;
      push_regs(7);
      do_start();
      while (cyc < acc + 1500) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_scl", bus.i2c_sclk, 1);
      check("async_rst_sda", sdat, 1);
      check("async_rst_busy", bus.busy, 0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      exp_q.delete();
      x0 = xfer_cnt;
      start_base = start_cnt;
      push_regs(7);
      do_start();
      wait_done("seq_after_rst", lat);
      check("rst_rerun_latency", lat, SEQ_CYC);
      check("rst_rerun_xfers", xfer_cnt - x0, 7);
      check("rst_rerun_queue_left", exp_q.size(), 0);

      // Slave NACKs byte1 of register 3.
      x0 = xfer_cnt; pa0 = partial_cnt;
      nack_en = 1'b1;
      nack_reg = 3;
      start_base = start_cnt;
`ifdef ACK_CHECK_EN
      push_regs(3);
      do_start();
      wait_done("nack_seq", lat);
      check("nack_latency", lat, NACK_CYC);
      check("nack_ack_error", bus.ack_error, 1);
      check("nack_busy", bus.busy, 0);
      check("nack_xfers", xfer_cnt - x0, 3);
      check("nack_partial", partial_cnt - pa0, 1);
      check("nack_queue_left", exp_q.size(), 0);
      nack_en = 1'b0;
      start_base = start_cnt;
      push_regs(7);
      do_start();
      check("ack_error_cleared", bus.ack_error, 0);
      wait_done("after_nack", lat);
      check("after_nack_latency", lat, SEQ_CYC);
      check("after_nack_ack_error", bus.ack_error, 0);
`else
      push_regs(7);
      do_start();
      wait_done("nack_ignored", lat);
      check("nack_ign_latency", lat, SEQ_CYC);
      check("nack_ign_ack_error", bus.ack_error, 0);
      check("nack_ign_xfers", xfer_cnt - x0, 7);
      check("nack_ign_partial", partial_cnt - pa0, 0);
      check("nack_ign_queue_left", exp_q.size(), 0);
      nack_en = 1'b0;
`endif

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
